win_scan_ctrl: RTL and testbench
================================

// Module: win_scan_ctrl
// PURPOSE
//  Sequences 32x32 window extraction from the 240x130 gray frame RAM into the 1024-entry window buffer.
//  Scans windows at stride 8: 27 columns x 13 rows = 351 windows per frame, column-major within a row.
//  For each window it issues the RAM read addresses and buffer write strobes, then hands the window to the compute engine.
//  It waits for the engine to finish before cutting the next window.
// PARAMETERS
//  IMG_W   240  frame width in pixels
//  IMG_H   130  frame height in pixels
//  WIN     32   window side (power of 2)
//  STRIDE  8    window step, both axes
//  ADDR_W  15   frame RAM address width
//  RD_LAT  1    frame RAM read latency, cycles from rd_addr to doutb valid (>=1)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  start        in   1       frame-start pulse; accepted only in IDLE
//  cal_done     in   1       compute engine finished the current window
//  rd_en        out  1       frame RAM port-B read enable
//  rd_addr      out  ADDR_W  frame RAM read address
//  buf_wr_en    out  1       window buffer write enable
//  buf_wr_addr  out  10      window buffer write address, y*WIN+x
//  win_valid    out  1       window buffer full and stable; held until cal_done
//  win_col      out  5       column index of current window, 0..26
//  win_row      out  4       row index of current window, 0..12
//  busy         out  1       high in every state except IDLE
//  frame_done   out  1       one-cycle pulse after the last window's cal_done
// BEHAVIOUR
//  Reset: every output is 0 and FSM is in IDLE. Reset mid-frame aborts immediately; no partial window is flagged.
//  FSM states: IDLE -> BASE -> CUT -> DRAIN -> WAIT_CAL -> NEXT -> (BASE | IDLE).
//   IDLE: on start go to BASE with col=row=0.
//   BASE: 1 cycle. base = row*STRIDE*IMG_W + col*STRIDE. Computed incrementally, no multiplier:
//    row_base += STRIDE*IMG_W per row; base = row_base + col*STRIDE.
//   CUT: exactly WIN*WIN cycles. rd_en=1; rd_addr = base + y*IMG_W + x.
//    x increments every cycle; on x wrap, y increments and the line pointer adds IMG_W.
//   DRAIN: RD_LAT cycles, then go to WAIT_CAL.
//   WAIT_CAL: win_valid=1. On cal_done go to NEXT. cal_done in any other state is ignored.
//   NEXT: 1 cycle.
//    col<26: col+1, go to BASE.
//    col==26, row<12: col=0, row+1, go to BASE.
//    col==26, row==12: pulse frame_done, go to IDLE.
//  Write path: buf_wr_en and buf_wr_addr are rd_en and {y,x} delayed RD_LAT cycles, so writes align with doutb.
//   Exactly 1024 writes per window, addresses 0..1023 in order.
//  Address bounds: max rd_addr = 23040+208+7440+31 = 30719, which fits ADDR_W=15. Width arithmetic carries no truncation.
//  start while busy is ignored. start in the same cycle as frame_done is ignored, because the FSM is still in NEXT.
//  win_col and win_row are stable from BASE through NEXT.
//  Per-window latency excluding WAIT_CAL: 1 + 1024 + RD_LAT + 1 cycles.
// CONFIGURATION
//  WIN_SCAN_STALL_CNT_EN:
//   Defined: adds output stall_cnt[15:0], which counts cycles spent in WAIT_CAL. Cleared on start, saturates at 0xFFFF, holds after frame_done.
//   Undefined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package win_scan_pkg holds:
//   typedef enum logic [2:0] win_scan_state_t {IDLE, BASE, CUT, DRAIN, WAIT_CAL, NEXT}.
//   Constants N_COL = (IMG_W-WIN)/STRIDE+1 = 27 and N_ROW = (IMG_H-WIN)/STRIDE+1 = 13.
//   Constant ROW_STEP = STRIDE*IMG_W.
//  Sub-module win_scan_dly: parameterised RD_LAT-deep shift register carrying {valid, 10-bit addr}; reset clears the valid bits.
// TESTING
//  1. Reset, then start; RAM model with RD_LAT=1:
//     - first window: rd_addr sequence 0,1..31,240..271,..,7440..7471
//     - buf_wr_addr 0..1023, each one cycle after its read
//     - win_valid rises at cycle 1+1024+1 after BASE.
//  2. Return cal_done 5 cycles after each win_valid rise:
//     - 351 win_valid pulses
//     - window (col 1, row 0) starts at rd_addr 8
//     - window (col 0, row 1) starts at rd_addr 1920
//     - last window (26,12) starts at 23248 and ends at 30719
//     - one frame_done pulse, then busy=0.
//  3. start pulsed during CUT and in the frame_done cycle: no restart, no address glitch; next start after IDLE begins a fresh frame at rd_addr 0.
//  4. cal_done pulsed during CUT and DRAIN: ignored. Window count stays correct. win_valid only drops after a cal_done seen in WAIT_CAL.
//  5. rst asserted at x=17 of window 40: next cycle all outputs 0 and FSM in IDLE. A subsequent start restarts at window (0,0).
//  6. Built with WIN_SCAN_STALL_CNT_EN and cal_done delay 3 per window: stall_cnt = 351*3 = 1053 at frame_done.
//     Separately, with cal_done held off: stall_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/win_scan_pkg.sv
// Shared types and constants for the window scan controller.
// The optional WAIT_CAL stall counter is enabled by defining WIN_SCAN_STALL_CNT_EN.
package win_scan_pkg;

  // Default frame geometry and timing
  localparam int IMG_W_DEF  = 240;
  localparam int IMG_H_DEF  = 130;
  localparam int WIN        = 32;
  localparam int STRIDE_DEF = 8;
  localparam int ADDR_W_DEF = 15;
  localparam int RD_LAT_DEF = 1;

  // Number of window positions along one axis
  function automatic int n_pos(input int img, input int win, input int stride);
    return ((img - win) / stride) + 32'sd1;
  endfunction

  localparam int N_COL    = n_pos(IMG_W_DEF, WIN, STRIDE_DEF);
  localparam int N_ROW    = n_pos(IMG_H_DEF, WIN, STRIDE_DEF);
  localparam int ROW_STEP = STRIDE_DEF * IMG_W_DEF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BASE     = 3'd1,
    CUT      = 3'd2,
    DRAIN    = 3'd3,
    WAIT_CAL = 3'd4,
    NEXT     = 3'd5
  } win_scan_state_t;

endpackage

// File: rtl/win_scan_dly.sv
// RD_LAT-deep delay line carrying {valid, buffer address} so that window
// buffer writes line up with the frame RAM read data.
module win_scan_dly #(
  parameter int DEPTH = 1,
  parameter int W     = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  logic [W-1:0] addr_i,
  output logic         valid_o,
  output logic [W-1:0] addr_o
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     addr_q [DEPTH];

  // Shift the read strobe and its buffer coordinate by one stage per cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      addr_q[0]  <= addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/win_scan_ctrl.sv
// Window scan controller: walks 32x32 windows across the gray frame at a
// fixed stride, streams each window into the window buffer, and waits for
// the compute engine before cutting the next one.
// Optional feature macro: WIN_SCAN_STALL_CNT_EN (adds stall_cnt_o).
module win_scan_ctrl
  import win_scan_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int STRIDE = STRIDE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cal_done_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              buf_wr_en_o,
  output logic [9:0]        buf_wr_addr_o,
  output logic              win_valid_o,
  output logic [4:0]        win_col_o,
  output logic [3:0]        win_row_o,
  output logic              busy_o,
`ifdef WIN_SCAN_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic              frame_done_o
);

  localparam int                 NC         = n_pos(IMG_W, WIN, STRIDE);
  localparam int                 NR         = n_pos(IMG_H, WIN, STRIDE);
  localparam logic [4:0]         LAST_COL   = 5'(NC - 1);
  localparam logic [3:0]         LAST_ROW   = 4'(NR - 1);
  localparam logic [4:0]         XY_LAST    = 5'(WIN - 1);
  localparam logic [ADDR_W-1:0]  ONE_A      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  LINE_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0]  COL_STEP   = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0]  ROW_STEP_A = ADDR_W'(STRIDE * IMG_W);
  localparam int                 DRAIN_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LAT - 1);

  win_scan_state_t     state_q, state_d;
  logic [4:0]          col_q, col_d;
  logic [3:0]          row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;  // first pixel of the current window row
  logic [ADDR_W-1:0]   col_off_q, col_off_d;    // col*STRIDE, built by repeated adds
  logic [ADDR_W-1:0]   line_q, line_d;          // first pixel of the current window line
  logic [4:0]          x_q, x_d;
  logic [4:0]          y_q, y_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                rd_en_q, rd_en_d;
  logic                win_valid_q, win_valid_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;

  // Next-state, scan counters and registered output values
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    row_base_d   = row_base_q;
    col_off_d    = col_off_q;
    line_d       = line_q;
    x_d          = x_q;
    y_d          = y_q;
    drain_d      = drain_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = '0;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = BASE;
          col_d      = 5'd0;
          row_d      = 4'd0;
          row_base_d = '0;
          col_off_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BASE: begin
        state_d   = CUT;
        x_d       = 5'd0;
        y_d       = 5'd0;
        line_d    = row_base_q + col_off_q;
        rd_addr_d = row_base_q + col_off_q;
        rd_en_d   = 1'b1;
      end
      CUT: begin
        if (x_q == XY_LAST) begin
          x_d = 5'd0;
          if (y_q == XY_LAST) begin
            y_d     = 5'd0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            y_d       = y_q + 5'd1;
            line_d    = line_q + LINE_STEP;
            rd_addr_d = line_q + LINE_STEP;
            rd_en_d   = 1'b1;
          end
        end else begin
          x_d       = x_q + 5'd1;
          rd_addr_d = rd_addr_q + ONE_A;
          rd_en_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = WAIT_CAL;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      WAIT_CAL: begin
        if (cal_done_i) begin
          state_d      = NEXT;
          frame_done_d = (col_q == LAST_COL) && (row_q == LAST_ROW);
        end else begin
          state_d = WAIT_CAL;
        end
      end
      NEXT: begin
        if (col_q != LAST_COL) begin
          col_d     = col_q + 5'd1;
          col_off_d = col_off_q + COL_STEP;
          state_d   = BASE;
        end else if (row_q != LAST_ROW) begin
          col_d      = 5'd0;
          col_off_d  = '0;
          row_d      = row_q + 4'd1;
          row_base_d = row_base_q + ROW_STEP_A;
          state_d    = BASE;
        end else begin
          col_d      = 5'd0;
          row_d      = 4'd0;
          col_off_d  = '0;
          row_base_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    win_valid_d = (state_d == WAIT_CAL);
    busy_d      = (state_d != IDLE);
  end

  // State, counters and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      col_q        <= 5'd0;
      row_q        <= 4'd0;
      row_base_q   <= '0;
      col_off_q    <= '0;
      line_q       <= '0;
      x_q          <= 5'd0;
      y_q          <= 5'd0;
      drain_q      <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      row_base_q   <= row_base_d;
      col_off_q    <= col_off_d;
      line_q       <= line_d;
      x_q          <= x_d;
      y_q          <= y_d;
      drain_q      <= drain_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      win_valid_q  <= win_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer write path follows the read path by the RAM latency
  win_scan_dly #(
    .DEPTH (RD_LAT),
    .W     (10)
  ) u_dly (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rd_en_q),
    .addr_i  ({y_q, x_q}),
    .valid_o (buf_wr_en_o),
    .addr_o  (buf_wr_addr_o)
  );

`ifdef WIN_SCAN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of cycles spent waiting on the compute engine
  always_comb begin
    stall_d = stall_q;
    if ((state_q == IDLE) && start_i) begin
      stall_d = 16'd0;
    end else if ((state_q == WAIT_CAL) && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign rd_en_o      = rd_en_q;
  assign rd_addr_o    = rd_addr_q;
  assign win_valid_o  = win_valid_q;
  assign win_col_o    = col_q;
  assign win_row_o    = row_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Directed bench for win_scan_ctrl. A full-size instance (240x130) checks
// the first rows of windows, start/cal_done filtering and mid-frame reset;
// a reduced instance (48x40, 3x2 windows) covers the end-of-frame behaviour.
module tb_win_scan_ctrl;

  logic clk = 1'b0;
  logic rst, start, cal_done, sel;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_win = 0;

  logic m_rd_en, m_buf_wr_en, m_win_valid, m_busy, m_frame_done;
  logic [14:0] m_rd_addr;
  logic [9:0]  m_buf_wr_addr;
  logic [4:0]  m_win_col;
  logic [3:0]  m_win_row;
  logic s_rd_en, s_buf_wr_en, s_win_valid, s_busy, s_frame_done;
  logic [14:0] s_rd_addr;
  logic [9:0]  s_buf_wr_addr;
  logic [4:0]  s_win_col;
  logic [3:0]  s_win_row;
`ifdef WIN_SCAN_STALL_CNT_EN
  logic [15:0] m_stall, s_stall;
`endif

  logic o_rd_en, o_buf_wr_en, o_win_valid, o_busy, o_frame_done;
  logic [14:0] o_rd_addr;
  logic [9:0]  o_buf_wr_addr;
  logic [4:0]  o_win_col;
  logic [3:0]  o_win_row;

  always #5 clk = ~clk;

  win_scan_ctrl u_main (
    .clk_i(clk), .rst_i(rst), .start_i(start & ~sel), .cal_done_i(cal_done & ~sel),
    .rd_en_o(m_rd_en), .rd_addr_o(m_rd_addr), .buf_wr_en_o(m_buf_wr_en),
    .buf_wr_addr_o(m_buf_wr_addr), .win_valid_o(m_win_valid), .win_col_o(m_win_col),
    .win_row_o(m_win_row), .busy_o(m_busy),
`ifdef WIN_SCAN_STALL_CNT_EN
    .stall_cnt_o(m_stall),
`endif
    .frame_done_o(m_frame_done)
  );

  win_scan_ctrl #(.IMG_W(48), .IMG_H(40)) u_small (
    .clk_i(clk), .rst_i(rst), .start_i(start & sel), .cal_done_i(cal_done & sel),
    .rd_en_o(s_rd_en), .rd_addr_o(s_rd_addr), .buf_wr_en_o(s_buf_wr_en),
    .buf_wr_addr_o(s_buf_wr_addr), .win_valid_o(s_win_valid), .win_col_o(s_win_col),
    .win_row_o(s_win_row), .busy_o(s_busy),
`ifdef WIN_SCAN_STALL_CNT_EN
    .stall_cnt_o(s_stall),
`endif
    .frame_done_o(s_frame_done)
  );

  assign o_rd_en       = sel ? s_rd_en       : m_rd_en;
  assign o_rd_addr     = sel ? s_rd_addr     : m_rd_addr;
  assign o_buf_wr_en   = sel ? s_buf_wr_en   : m_buf_wr_en;
  assign o_buf_wr_addr = sel ? s_buf_wr_addr : m_buf_wr_addr;
  assign o_win_valid   = sel ? s_win_valid   : m_win_valid;
  assign o_win_col     = sel ? s_win_col     : m_win_col;
  assign o_win_row     = sel ? s_win_row     : m_win_row;
  assign o_busy        = sel ? s_busy        : m_busy;
  assign o_frame_done  = sel ? s_frame_done  : m_frame_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rd_en"},       32'(o_rd_en),       32'd0);
    chk({tag, "_rd_addr"},     32'(o_rd_addr),     32'd0);
    chk({tag, "_buf_wr_en"},   32'(o_buf_wr_en),   32'd0);
    chk({tag, "_buf_wr_addr"}, 32'(o_buf_wr_addr), 32'd0);
    chk({tag, "_win_valid"},   32'(o_win_valid),   32'd0);
    chk({tag, "_win_col"},     32'(o_win_col),     32'd0);
    chk({tag, "_win_row"},     32'(o_win_row),     32'd0);
    chk({tag, "_busy"},        32'(o_busy),        32'd0);
    chk({tag, "_frame_done"},  32'(o_frame_done),  32'd0);
  endtask

  // Runs one window from NEXT/BASE through its cal_done; ends sampling NEXT.
  task automatic run_window(input int col, input int row, input int dly,
                            input bit inj_cal, input bit inj_start);
    int  wimg, ncol, nrow, base, nr, nw, i, last_addr;
    bit  last;
    wimg = sel ? 48 : 240;
    ncol = sel ? 3 : 27;
    nrow = sel ? 2 : 13;
    base = row * 8 * wimg + col * 8;
    last = (col == ncol - 1) && (row == nrow - 1);
    for (i = 0; i < 2000 && (o_rd_en !== 1'b1); i++) tick();
    chk("first_rd_en", 32'(o_rd_en), 32'd1);
    chk("win_start_addr", 32'(o_rd_addr), 32'(base));
    chk("win_col", 32'(o_win_col), 32'(col));
    chk("win_row", 32'(o_win_row), 32'(row));
    nr = 0;
    nw = 0;
    last_addr = -1;
    for (i = 0; i < 1100 && (o_win_valid !== 1'b1); i++) begin
      start    = 1'b0;
      cal_done = 1'b0;
      if (o_rd_en === 1'b1) begin
        chk("rd_addr", 32'(o_rd_addr), 32'(base + (nr / 32) * wimg + (nr % 32)));
        last_addr = int'(o_rd_addr);
        nr++;
      end
      if (o_buf_wr_en === 1'b1) begin
        chk("buf_wr_addr", 32'(o_buf_wr_addr), 32'(nw));
        nw++;
      end
      if (inj_start && nr == 300) start = 1'b1;
      if (inj_cal && (nr == 500 || (o_rd_en === 1'b0 && o_buf_wr_en === 1'b1))) cal_done = 1'b1;
      tick();
    end
    start    = 1'b0;
    cal_done = 1'b0;
    chk("win_valid_rise", 32'(o_win_valid), 32'd1);
    chk("win_valid_latency", 32'(i), 32'd1025);
    chk("read_count", 32'(nr), 32'd1024);
    chk("write_count", 32'(nw), 32'd1024);
    chk("win_end_addr", 32'(last_addr), 32'(base + 31 * wimg + 31));
    if (o_win_valid === 1'b1) n_win++;
    for (int k = 1; k < dly; k++) tick();
    chk("win_valid_hold", 32'(o_win_valid), 32'd1);
    cal_done = 1'b1;
    tick();
    cal_done = 1'b0;
    chk("win_valid_drop", 32'(o_win_valid), 32'd0);
    chk("frame_done", 32'(o_frame_done), 32'(last));
    chk("busy_in_next", 32'(o_busy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cal_done = 1'b0; sel = 1'b0;
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;
    tick();
    chk_idle_zero("idle");

    // Full-size frame: rows 0 and part of 1
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("base_busy", 32'(o_busy), 32'd1);
    chk("base_rd_en", 32'(o_rd_en), 32'd0);
    for (int w = 0; w < 40; w++) begin
      run_window(w % 27, w / 27, 5, (w == 1), (w == 0));
    end
    chk("main_win_count", 32'(n_win), 32'd40);

    // Reset in the middle of window 40 (col 13, row 1)
    for (int i = 0; i < 10 && (o_rd_en !== 1'b1); i++) tick();
    for (int i = 0; i < 17; i++) tick();
    chk("w40_rd_addr_x17", 32'(o_rd_addr), 32'd2041);
    chk("w40_col", 32'(o_win_col), 32'd13);
    chk("w40_row", 32'(o_win_row), 32'd1);
    chk("w40_buf_wr_addr", 32'(o_buf_wr_addr), 32'd16);
    rst = 1'b1;
    tick();
    chk_idle_zero("midreset");
    rst = 1'b0;
    tick();
    tick();
    chk("post_reset_busy", 32'(o_busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_window(0, 0, 5, 1'b0, 1'b0);

    // Reduced frame: 3 x 2 windows, end-of-frame behaviour
    sel   = 1'b1;
    n_win = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef WIN_SCAN_STALL_CNT_EN
    chk("stall_clear", 32'(s_stall), 32'd0);
`endif
    for (int w = 0; w < 6; w++) begin
      run_window(w % 3, w / 3, 3, 1'b0, 1'b0);
    end
    chk("small_win_count", 32'(n_win), 32'd6);
`ifdef WIN_SCAN_STALL_CNT_EN
    chk("stall_frame", 32'(s_stall), 32'd18);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("after_frame_busy", 32'(o_busy), 32'd0);
    chk("after_frame_done", 32'(o_frame_done), 32'd0);
    chk("after_frame_rd_en", 32'(o_rd_en), 32'd0);
    tick();
    tick();
    tick();
    chk("start_in_done_ignored", 32'(o_busy), 32'd0);
`ifdef WIN_SCAN_STALL_CNT_EN
    chk("stall_hold", 32'(s_stall), 32'd18);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_busy", 32'(o_busy), 32'd1);
    run_window(0, 0, 3, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
